// File: rtl/sipo_rx.sv
// sipo_rx: serial-in parallel-out receiver, MSB first, started by a strobe.
// Completed words are presented through a valid/ack holding register.
// A completed word that arrives while the previous one is still unconsumed
// is dropped and sets the sticky overrun flag.
// Optional feature macro: PARITY_EN (adds one even-parity bit per frame, reported on perr).
module sipo_rx #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         din,
    input  logic         start,
    input  logic         ack,
    output logic [n-1:0] q,
    output logic         valid,
    output logic         busy,
    output logic         overrun,
    output logic         perr
);

    localparam int CW = (n > 1) ? $clog2(n) : 1;
`ifdef PARITY_EN
    // The full word has to be held while the parity bit is received.
    localparam int SRW = n;
`else
    // Bit 0 is taken straight from din on the commit edge, so n-1 bits are enough.
    localparam int SRW = n - 1;
`endif

    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t CNT_LAST = cnt_t'(n - 1);
    localparam cnt_t CNT_ONE  = cnt_t'(1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef PARITY_EN
        , PAR
`endif
    } state_t;

    state_t           state, state_n;
    logic [SRW-1:0]   sr, sr_n;
    cnt_t             cnt, cnt_n;
    logic             commit;
    logic [n-1:0]     word;
    logic [n-1:0]     q_n;
    logic             valid_n;
    logic             overrun_n;
`ifdef PARITY_EN
    logic             par_bit;
    logic             perr_n;
`endif

    assign busy = (state != IDLE);

    // Frame state, shift register and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            sr    <= sr_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state logic; flags the edge on which a complete word is committed.
    always_comb begin
        state_n = state;
        sr_n    = sr;
        cnt_n   = cnt;
        commit  = 1'b0;
`ifdef PARITY_EN
        word    = sr;
        par_bit = din;
`else
        word    = {sr, din};
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    sr_n    = SRW'(din);
                    cnt_n   = CNT_ONE;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                sr_n = SRW'({sr, din});
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
`ifdef PARITY_EN
                    state_n = PAR;
`else
                    commit  = 1'b1;
                    state_n = IDLE;
`endif
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
`ifdef PARITY_EN
            PAR: begin
                commit  = 1'b1;
                state_n = IDLE;
            end
`endif
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Holding register rules: commit if empty or being consumed, else drop and flag overrun.
    always_comb begin
        q_n       = q;
        valid_n   = valid;
        overrun_n = overrun;
`ifdef PARITY_EN
        perr_n    = perr;
`endif
        if (commit) begin
            if (!valid || ack) begin
                q_n     = word;
                valid_n = 1'b1;
`ifdef PARITY_EN
                perr_n  = ^{word, par_bit};
`endif
            end else begin
                overrun_n = 1'b1;
            end
        end else if (valid && ack) begin
            valid_n = 1'b0;
        end
    end

    // Holding register, valid flag and sticky overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            q       <= q_n;
            valid   <= valid_n;
            overrun <= overrun_n;
        end
    end

`ifdef PARITY_EN
    // Parity error flag for the word currently held in q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perr <= 1'b0;
        end else begin
            perr <= perr_n;
        end
    end
`else
    assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
// Self-checking bench for sipo_rx: directed table, hand-written corner
// sequences and a randomized phase checked against a frame-level model.
module tb_sipo_rx;

    localparam int N = 8;
`ifdef PARITY_EN
    localparam int FLEN = N + 1;
`else
    localparam int FLEN = N;
`endif

    logic         clk;
    logic         rst;
    logic         din;
    logic         start;
    logic         ack;
    logic [N-1:0] q;
    logic         valid;
    logic         busy;
    logic         overrun;
    logic         perr;

    int total;
    int bad;

    sipo_rx #(.n(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .start   (start),
        .ack     (ack),
        .q       (q),
        .valid   (valid),
        .busy    (busy),
        .overrun (overrun),
        .perr    (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-level reference: position within frame plus accumulated value.
    int           m_pos;
    int unsigned  m_word;
    logic         m_p;
    logic [N-1:0] m_q;
    logic         m_valid;
    logic         m_ovr;
    logic         m_perr;

    task automatic model_reset();
        m_pos   = 0;
        m_word  = 0;
        m_p     = 1'b0;
        m_q     = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_perr  = 1'b0;
    endtask

    task automatic model_step();
        bit done;
        done = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            if (m_pos == 0) begin
                if (start) begin
                    m_word = din;
                    m_pos  = 1;
                end
            end else begin
                if (m_pos < N) m_word = m_word * 2 + din;
                else           m_p    = din;
                m_pos = m_pos + 1;
                if (m_pos == FLEN) begin
                    done  = 1'b1;
                    m_pos = 0;
                end
            end
            if (done) begin
                if (!m_valid || ack) begin
                    m_q     = m_word[N-1:0];
                    m_valid = 1'b1;
`ifdef PARITY_EN
                    m_perr  = (($countones(m_word) + m_p) % 2) == 1;
`else
                    m_perr  = 1'b0;
`endif
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && ack) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("q",       32'(q),       32'(m_q));
        chk("valid",   32'(valid),   32'(m_valid));
        chk("busy",    32'(busy),    32'(m_pos != 0));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("perr",    32'(perr),    32'(m_perr));
    endtask

    // One clock: inputs are stable across the edge, outputs compared 1 ns after.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle(input logic a);
        start = 1'b0;
        din   = 1'b0;
        ack   = a;
        tick();
        ack   = 1'b0;
    endtask

    // Sends a full frame; ack_last is asserted on the commit edge only.
    task automatic send_frame(input logic [N-1:0] w, input logic p, input logic ack_last);
        for (int i = 0; i < N; i++) begin
            start = (i == 0);
            din   = w[N-1-i];
            ack   = (FLEN == N) && ack_last && (i == N - 1);
            tick();
        end
`ifdef PARITY_EN
        start = 1'b0;
        din   = p;
        ack   = ack_last;
        tick();
`else
        if (p) begin end
`endif
        start = 1'b0;
        din   = 1'b0;
        ack   = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] w;
        logic         ack_pre;
        logic [N-1:0] exp_q;
        logic         exp_valid;
        logic         exp_ovr;
    } vec_t;

    vec_t tbl[5];

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        din   = 1'b0;
        start = 1'b0;
        ack   = 1'b0;
        model_reset();

        tbl[0] = '{w: 8'hA5, ack_pre: 1'b0, exp_q: 8'hA5, exp_valid: 1'b1, exp_ovr: 1'b0};
        tbl[1] = '{w: 8'h3C, ack_pre: 1'b1, exp_q: 8'h3C, exp_valid: 1'b1, exp_ovr: 1'b0};
        tbl[2] = '{w: 8'h11, ack_pre: 1'b1, exp_q: 8'h11, exp_valid: 1'b1, exp_ovr: 1'b0};
        tbl[3] = '{w: 8'h22, ack_pre: 1'b0, exp_q: 8'h11, exp_valid: 1'b1, exp_ovr: 1'b1};
        tbl[4] = '{w: 8'h5A, ack_pre: 1'b1, exp_q: 8'h5A, exp_valid: 1'b1, exp_ovr: 1'b1};

        #12;
        chk("rst_q",       32'(q),       32'h0);
        chk("rst_valid",   32'(valid),   32'h0);
        chk("rst_busy",    32'(busy),    32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_perr",    32'(perr),    32'h0);
        tick();
        rst = 1'b0;
        idle(1'b0);

        // Directed table: even parity on every frame, so perr must stay 0.
        foreach (tbl[k]) begin
            idle(tbl[k].ack_pre);
            send_frame(tbl[k].w, ^tbl[k].w, 1'b0);
            chk("tbl_q",       32'(q),       32'(tbl[k].exp_q));
            chk("tbl_valid",   32'(valid),   32'(tbl[k].exp_valid));
            chk("tbl_overrun", 32'(overrun), 32'(tbl[k].exp_ovr));
            chk("tbl_busy",    32'(busy),    32'h0);
            chk("tbl_perr",    32'(perr),    32'h0);
        end
        idle(1'b1);
        chk("ovr_sticky_after_ack", 32'(overrun), 32'h1);
        chk("valid_cleared_by_ack", 32'(valid),   32'h0);

        // Back-to-back frames; ack on the second commit edge keeps valid high.
        do_reset();
        send_frame(8'h3C, ^8'h3C, 1'b0);
        chk("b2b_q1", 32'(q), 32'h3C);
        send_frame(8'hC3, ^8'hC3, 1'b1);
        chk("b2b_q2",       32'(q),       32'hC3);
        chk("b2b_valid",    32'(valid),   32'h1);
        chk("b2b_overrun",  32'(overrun), 32'h0);

        // Reset in the middle of a word, then a clean frame.
        idle(1'b1);
        for (int i = 0; i < 4; i++) begin
            start = (i == 0);
            din   = 1'b1;
            tick();
        end
        start = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_q",     32'(q),     32'h0);
        chk("mid_rst_valid", 32'(valid), 32'h0);
        chk("mid_rst_busy",  32'(busy),  32'h0);
        model_reset();
        tick();
        rst = 1'b0;
        send_frame(8'h5A, ^8'h5A, 1'b0);
        chk("after_rst_q", 32'(q), 32'h5A);

        // Parity flag.
        idle(1'b1);
        send_frame(8'h07, 1'b1, 1'b0);
        chk("par_good_perr", 32'(perr), 32'h0);
        idle(1'b1);
        send_frame(8'h07, 1'b0, 1'b0);
`ifdef PARITY_EN
        chk("par_bad_perr", 32'(perr), 32'h1);
`else
        chk("par_bad_perr", 32'(perr), 32'h0);
`endif

        // Randomized stream against the reference model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            start = ($urandom_range(0, 2) == 0);
            din   = 1'($urandom_range(0, 1));
            ack   = 1'($urandom_range(0, 1));
            tick();
        end
        start = 1'b0;
        ack   = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
